// File: rtl/fetch_seq_if.sv
// Sequencer <-> control-unit/ROM signal bundle for fetch_seq.
// FETCH_SEQ_RETCNT_EN adds the retired-instruction counter output.
interface fetch_seq_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16
);
    logic [INSTR_W-1:0] instr;
    logic               alu_zero;
    logic               s_inc;
    logic               s_inm;
    logic               we3;
    logic               fin;
    logic               go;
    logic [PC_W-1:0]    pc;
    logic [5:0]         opcode;
    logic               z;
    logic               halted;
`ifdef FETCH_SEQ_RETCNT_EN
    logic [15:0]        retired;

    modport slave (
        input  instr, alu_zero, s_inc, s_inm, we3, fin, go,
        output pc, opcode, z, halted, retired
    );
    modport master (
        output instr, alu_zero, s_inc, s_inm, we3, fin, go,
        input  pc, opcode, z, halted, retired
    );
`else
    modport slave (
        input  instr, alu_zero, s_inc, s_inm, we3, fin, go,
        output pc, opcode, z, halted
    );
    modport master (
        output instr, alu_zero, s_inc, s_inm, we3, fin, go,
        input  pc, opcode, z, halted
    );
`endif
endinterface

// File: rtl/fetch_seq.sv
// Single-cycle instruction sequencer: PC, zero flag and BOOT/RUN/HALT control.
// FETCH_SEQ_RETCNT_EN adds a 16-bit retired-instruction counter.
module fetch_seq #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    fetch_seq_if.slave  sq
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            z_q, z_d;
    logic            halted_q, halted_d;
    logic [5:0]      opcode;
    logic            halt_hit;

    assign opcode   = sq.instr[INSTR_W-1 -: 6];
    // The control unit leaves fin asserted across opcodes; only 1111 opcodes halt.
    assign halt_hit = sq.fin & (opcode[3:0] == 4'b1111);

`ifdef FETCH_SEQ_RETCNT_EN
    logic [15:0] ret_q, ret_d;
    assign sq.retired = ret_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= '0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
`ifdef FETCH_SEQ_RETCNT_EN
            ret_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            z_q      <= z_d;
            halted_q <= halted_d;
`ifdef FETCH_SEQ_RETCNT_EN
            ret_q    <= ret_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        z_d      = z_q;
        halted_d = halted_q;
`ifdef FETCH_SEQ_RETCNT_EN
        ret_d    = ret_q;
`endif
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (halt_hit) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    pc_d = sq.s_inc ? pc_q + PC_W'(1) : sq.instr[PC_W-1:0];
                    // Only ALU writes update z; jz/jnz see the flag from an earlier instruction.
                    if (sq.we3 && !sq.s_inm)
                        z_d = sq.alu_zero;
`ifdef FETCH_SEQ_RETCNT_EN
                    ret_d = ret_q + 16'd1;
`endif
                end
            end
            HALT: begin
                if (sq.go) begin
                    state_d  = RUN;
                    halted_d = 1'b0;
                    pc_d     = pc_q + PC_W'(1);
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign sq.pc     = pc_q;
    assign sq.opcode = opcode;
    assign sq.z      = z_q;
    assign sq.halted = halted_q;
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: per-cycle comparison against a behavioural model
// plus literal checks of the scenario values.
module tb_fetch_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_seq_if #(.PC_W(10), .INSTR_W(16)) sq ();
    fetch_seq #(.PC_W(10), .INSTR_W(16)) dut (.clk(clk), .reset(reset), .sq(sq));

    // Behavioural model: mode 0 = booting, 1 = running, 2 = halted.
    int          m_mode;
    logic [9:0]  m_pc;
    logic        m_z, m_h;
    logic [15:0] m_ret;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_pc <= 10'd0; m_z <= 1'b0; m_h <= 1'b0; m_ret <= 16'd0;
        end else if (m_mode == 0) begin
            m_mode <= 1;
        end else if (m_mode == 1) begin
            if (sq.fin && sq.instr[13:10] == 4'hF) begin
                m_mode <= 2; m_h <= 1'b1;
            end else begin
                m_pc  <= sq.s_inc ? 10'((m_pc + 1) % 1024) : sq.instr[9:0];
                if (sq.we3 && !sq.s_inm) m_z <= sq.alu_zero;
                m_ret <= 16'((m_ret + 1) % 65536);
            end
        end else if (sq.go) begin
            m_mode <= 1; m_h <= 1'b0; m_pc <= 10'((m_pc + 1) % 1024);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_pc", 32'(sq.pc), 32'(m_pc));
        chk("model_z", 32'(sq.z), 32'(m_z));
        chk("model_halted", 32'(sq.halted), 32'(m_h));
        chk("model_opcode", 32'(sq.opcode), 32'(sq.instr[15:10]));
`ifdef FETCH_SEQ_RETCNT_EN
        chk("model_retired", 32'(sq.retired), 32'(m_ret));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        sq.instr = 16'h0; sq.alu_zero = 0; sq.s_inc = 0; sq.s_inm = 0;
        sq.we3 = 0; sq.fin = 0; sq.go = 0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pc", 32'(sq.pc), 32'd0);
        chk("rst_z", 32'(sq.z), 32'd0);
        chk("rst_halted", 32'(sq.halted), 32'd0);
        reset = 1'b0; sq.s_inc = 1;
        tick(); chk("boot_pc", 32'(sq.pc), 32'd0);
        tick(); chk("first_run_pc", 32'(sq.pc), 32'd1);

        sq.s_inc = 0; sq.instr = 16'd1022;
        tick(); chk("jump_1022", 32'(sq.pc), 32'd1022);
        sq.s_inc = 1;
        tick(); chk("inc_1023", 32'(sq.pc), 32'd1023);
        tick(); chk("wrap_0", 32'(sq.pc), 32'd0);
        sq.s_inc = 0; sq.instr = 16'h02A5;
        tick(); chk("jump_2a5", 32'(sq.pc), 32'h2A5);

        sq.s_inc = 1; sq.we3 = 1; sq.s_inm = 0; sq.alu_zero = 1;
        tick(); chk("z_set", 32'(sq.z), 32'd1);
        sq.s_inm = 1; sq.alu_zero = 0;
        tick(); chk("z_inm_hold", 32'(sq.z), 32'd1);
        sq.we3 = 0; sq.s_inm = 0;
        tick(); chk("z_nowe_hold", 32'(sq.z), 32'd1);
        sq.we3 = 1;
        tick(); chk("z_clear", 32'(sq.z), 32'd0);
        sq.alu_zero = 1;
        tick(); chk("z_reset1", 32'(sq.z), 32'd1);

        sq.we3 = 0; sq.s_inc = 0; sq.instr = 16'd7;
        tick(); chk("pc_7", 32'(sq.pc), 32'd7);
        sq.instr = {6'b001111, 10'h0}; sq.fin = 1; sq.s_inc = 1; sq.we3 = 1; sq.alu_zero = 0;
        tick();
        chk("halt_h", 32'(sq.halted), 32'd1);
        chk("halt_pc", 32'(sq.pc), 32'd7);
        chk("halt_z", 32'(sq.z), 32'd1);
        sq.fin = 0; sq.we3 = 0;
        for (int i = 0; i < 10; i++) begin
            sq.s_inc = i[0];
            tick(); chk("halt_hold_pc", 32'(sq.pc), 32'd7);
        end
        sq.go = 1;
        tick();
        chk("go_pc", 32'(sq.pc), 32'd8);
        chk("go_halted", 32'(sq.halted), 32'd0);
        sq.go = 0;

        sq.instr = {6'b000010, 10'h0}; sq.fin = 1; sq.s_inc = 1;
        tick();
        chk("spur_pc", 32'(sq.pc), 32'd9);
        chk("spur_halted", 32'(sq.halted), 32'd0);
        sq.fin = 0; sq.go = 1;
        tick(); chk("go_in_run_pc", 32'(sq.pc), 32'd10);
        sq.go = 0;

        sq.s_inc = 0; sq.instr = 16'h0155;
        tick(); chk("pc_155", 32'(sq.pc), 32'h155);
        sq.instr = {6'b111111, 10'h0}; sq.fin = 1;
        tick(); sq.fin = 0;
        tick();
        chk("halt2_pc", 32'(sq.pc), 32'h155);
        chk("halt2_z", 32'(sq.z), 32'd1);
        chk("halt2_h", 32'(sq.halted), 32'd1);
`ifdef FETCH_SEQ_RETCNT_EN
        chk("retired_14", 32'(sq.retired), 32'd14);
`endif
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_pc", 32'(sq.pc), 32'd0);
        chk("async_z", 32'(sq.z), 32'd0);
        chk("async_h", 32'(sq.halted), 32'd0);
`ifdef FETCH_SEQ_RETCNT_EN
        chk("async_retired", 32'(sq.retired), 32'd0);
`endif
        @(posedge clk);
        #2 reset = 1'b0; sq.s_inc = 1; sq.instr = 16'h0;
        tick(); chk("reboot_pc", 32'(sq.pc), 32'd0);
        tick(); chk("rerun_pc", 32'(sq.pc), 32'd1);
        tick(); chk("rerun_pc2", 32'(sq.pc), 32'd2);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
